// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the pooling / fully-connected stage.
// Holds the sequencer state encoding and the layer-size defaults that the
// neighbouring pooling and FC blocks agree on.
package fc_layer_sequencer_pkg;

  // Sequencer states. BIAS is only reachable when FC_BIAS_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4,
    ST_BIAS  = 3'd5
  } fc_state_t;

  // Layer geometry shared with the pooling stage.
  localparam int FC_NUM_INPUTS  = 507;
  localparam int FC_NUM_NEURONS = 10;
  localparam int FC_MEM_LATENCY = 2;

  // Bit positions inside the {first, valid} alignment pipeline word.
  localparam int PIPE_VALID = 0;
  localparam int PIPE_FIRST = 1;

endpackage

// File: rtl/latency_shift.sv
// Fixed-depth shift register carrying a 2-bit {first, valid} tag so that
// MAC strobes line up with data arriving from the read-latency memories.
// A synchronous clear empties the whole pipe in one edge.
module latency_shift #(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_pipe [DEPTH];

  // Shift one stage per clock; clear drops everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= 2'b00;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: walks max-pool results and weights for
// each output neuron, drives MAC clear/enable aligned to memory latency,
// strobes one result write per neuron and pulses done at the end.
// Optional feature macro: FC_BIAS_EN (adds a per-neuron BIAS load cycle).
//
// Handshake: start is a one-cycle request honoured only in IDLE; pause
// stalls address issue in RUN only; done is a single-cycle pulse.
module fc_layer_sequencer
  import fc_layer_sequencer_pkg::*;
#(
  parameter int dataWidthCount      = 10,
  parameter int dataWidthWeightAddr = 13,
  parameter int dataWidthNeuron     = 4,
  parameter int numInputs           = FC_NUM_INPUTS,
  parameter int numNeurons          = FC_NUM_NEURONS,
  parameter int memLatency          = FC_MEM_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           pause,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [dataWidthCount-1:0]      addr_max,
  output logic [dataWidthWeightAddr-1:0] addr_weight,
  output logic                           mac_clr,
  output logic                           mac_en,
  output logic                           result_we,
  output logic [dataWidthNeuron-1:0]     result_addr,
`ifdef FC_BIAS_EN
  output logic                           bias_rd_en,
  output logic [dataWidthNeuron-1:0]     bias_addr,
  output logic                           mac_load_bias,
`endif
  output logic [2:0]                     dbg_state
);

  localparam int CW = $clog2(memLatency + 1);
  localparam logic [dataWidthCount-1:0]  LAST_INPUT  = dataWidthCount'(numInputs - 1);
  localparam logic [dataWidthNeuron-1:0] LAST_NEURON = dataWidthNeuron'(numNeurons - 1);
  localparam logic [CW-1:0]              DRAIN_LAST  = CW'(memLatency - 1);

`ifdef FC_BIAS_EN
  // Each neuron starts with a bias load; the first product then accumulates.
  localparam fc_state_t NEURON_ENTRY = ST_BIAS;
  localparam bit        CLR_ON_FIRST = 1'b0;
`else
  localparam fc_state_t NEURON_ENTRY = ST_RUN;
  localparam bit        CLR_ON_FIRST = 1'b1;
`endif

  fc_state_t                      r_state;
  fc_state_t                      w_state_next;
  logic [dataWidthCount-1:0]      r_addr_max;
  logic [dataWidthWeightAddr-1:0] r_addr_weight;
  logic [dataWidthNeuron-1:0]     r_neuron;
  logic [CW-1:0]                  r_drain_cnt;

  logic       w_rd_en;
  logic       w_first;
  logic       w_result_we;
  logic       w_done;
  logic [1:0] w_pipe_q;
`ifdef FC_BIAS_EN
  logic       w_bias_rd;
  logic [1:0] w_bias_q;
`endif

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_first      = 1'b0;
    w_result_we  = 1'b0;
    w_done       = 1'b0;
`ifdef FC_BIAS_EN
    w_bias_rd    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = NEURON_ENTRY;
        end
      end
      ST_RUN: begin
        if (!pause) begin
          w_rd_en = 1'b1;
          w_first = CLR_ON_FIRST && (r_addr_max == '0);
          if (r_addr_max == LAST_INPUT) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_next = ST_STORE;
        end
      end
      ST_STORE: begin
        w_result_we = 1'b1;
        if (r_neuron == LAST_NEURON) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = NEURON_ENTRY;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
`ifdef FC_BIAS_EN
      ST_BIAS: begin
        w_bias_rd    = 1'b1;
        w_state_next = ST_RUN;
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address, neuron and drain counters; weight address never rewinds
  // between neurons so no multiplier is needed to locate each row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_max    <= '0;
      r_addr_weight <= '0;
      r_neuron      <= '0;
      r_drain_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr_max    <= '0;
            r_addr_weight <= '0;
            r_neuron      <= '0;
          end
        end
        ST_RUN: begin
          r_drain_cnt <= '0;
          if (!pause) begin
            r_addr_weight <= r_addr_weight + 1'b1;
            if (r_addr_max == LAST_INPUT) begin
              r_addr_max <= '0;
            end else begin
              r_addr_max <= r_addr_max + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        ST_STORE: begin
          if (r_neuron != LAST_NEURON) begin
            r_neuron <= r_neuron + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Delay {first, valid} of each read so MAC strobes meet the returning data.
  latency_shift #(
    .DEPTH(memLatency)
  ) u_mac_shift (
    .i_clk(clk),
    .i_clr(rst),
    .i_d  ({w_first, w_rd_en}),
    .o_q  (w_pipe_q)
  );

`ifdef FC_BIAS_EN
  // Bias reads travel through their own copy of the same alignment pipe;
  // both tag bits are set so the load strobe is their conjunction.
  latency_shift #(
    .DEPTH(memLatency)
  ) u_bias_shift (
    .i_clk(clk),
    .i_clr(rst),
    .i_d  ({w_bias_rd, w_bias_rd}),
    .o_q  (w_bias_q)
  );

  assign bias_rd_en    = w_bias_rd;
  assign bias_addr     = r_neuron;
  assign mac_load_bias = w_bias_q[PIPE_VALID] & w_bias_q[PIPE_FIRST];
`endif

  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;
  assign rd_en       = w_rd_en;
  assign addr_max    = r_addr_max;
  assign addr_weight = r_addr_weight;
  assign mac_en      = w_pipe_q[PIPE_VALID];
  assign mac_clr     = w_pipe_q[PIPE_FIRST];
  assign result_we   = w_result_we;
  assign result_addr = r_neuron;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer with a 4-input, 3-neuron, latency-2 layer.
// A schedule model derives every output per cycle from the stimulus tables;
// a MAC model fed by the DUT strobes is checked against golden dot products.
module tb_fc_layer_sequencer;

  localparam int NI  = 4;
  localparam int NN  = 3;
  localparam int LAT = 2;
  localparam int NC  = 64;
`ifdef FC_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  localparam int PER_N    = NI + LAT + 1 + (BIAS ? 1 : 0);
  localparam int DONE_NOM = NN * PER_N + 1;

  logic        clk = 1'b0;
  logic        rst, start, pause;
  logic        busy, done, rd_en, mac_clr, mac_en, result_we;
  logic [9:0]  addr_max;
  logic [12:0] addr_weight;
  logic [3:0]  result_addr;
  logic [2:0]  dbg_state;
`ifdef FC_BIAS_EN
  logic        bias_rd_en, mac_load_bias;
  logic [3:0]  bias_addr;
`endif

  // clock
  always #5 clk = ~clk;

  fc_layer_sequencer #(
    .dataWidthCount(10), .dataWidthWeightAddr(13), .dataWidthNeuron(4),
    .numInputs(NI), .numNeurons(NN), .memLatency(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .busy(busy), .done(done), .rd_en(rd_en),
    .addr_max(addr_max), .addr_weight(addr_weight),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .result_we(result_we), .result_addr(result_addr),
`ifdef FC_BIAS_EN
    .bias_rd_en(bias_rd_en), .bias_addr(bias_addr), .mac_load_bias(mac_load_bias),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // stimulus tables, indexed by cycle
  bit start_tbl [NC];
  bit pause_tbl [NC];
  bit rst_tbl   [NC];

  // expected per-cycle outputs
  bit e_busy [NC];
  bit e_done [NC];
  bit e_rd   [NC];
  bit e_achk [NC];
  int e_am   [NC];
  int e_aw   [NC];
  bit e_me   [NC];
  bit e_clr  [NC];
  bit e_we   [NC];
  bit e_rchk [NC];
  int e_ra   [NC];
  bit e_brd  [NC];
  int e_ba   [NC];
  bit e_lb   [NC];

  task automatic clear_cycle(input int c);
    e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_achk[c] = 0; e_am[c] = 0;
    e_aw[c] = 0; e_me[c] = 0; e_clr[c] = 0; e_we[c] = 0; e_rchk[c] = 0;
    e_ra[c] = 0; e_brd[c] = 0; e_ba[c] = 0; e_lb[c] = 0;
  endtask

  task automatic init_tables();
    for (int c = 0; c < NC; c++) begin
      start_tbl[c] = 0; pause_tbl[c] = 0; rst_tbl[c] = 0;
      clear_cycle(c);
    end
  endtask

  // Schedule of one full layer started at cycle s: optional bias cycle,
  // NI issued reads (pause cycles inserted), LAT drain cycles, one store.
  task automatic model_build(input int s);
    int t;
    t = s + 1;
    for (int n = 0; n < NN; n++) begin
      if (BIAS) begin
        e_busy[t] = 1; e_brd[t] = 1; e_ba[t] = n; e_lb[t+LAT] = 1;
        t++;
      end
      for (int i = 0; i < NI; i++) begin
        while (pause_tbl[t] && t < NC - 8) begin
          e_busy[t] = 1; e_achk[t] = 1; e_am[t] = i; e_aw[t] = n * NI + i;
          t++;
        end
        e_busy[t] = 1; e_rd[t] = 1; e_achk[t] = 1; e_am[t] = i; e_aw[t] = n * NI + i;
        e_me[t+LAT]  = 1;
        e_clr[t+LAT] = (i == 0) && !BIAS;
        t++;
      end
      for (int d = 0; d < LAT; d++) begin
        e_busy[t] = 1;
        t++;
      end
      e_busy[t] = 1; e_we[t] = 1; e_rchk[t] = 1; e_ra[t] = n;
      t++;
    end
    e_busy[t] = 1; e_done[t] = 1;
  endtask

  // Reset sampled at the end of cycle r: nothing scheduled later survives
  // and the cycle after shows all-zero outputs.
  task automatic model_reset(input int r);
    for (int c = r + 1; c < NC; c++) clear_cycle(c);
    e_achk[r+1] = 1; e_rchk[r+1] = 1;
  endtask

  // memories and reference MAC
  logic [7:0]  in_mem   [16];
  logic [15:0] w_mem    [64];
  logic [15:0] bias_mem [16];
  logic [31:0] golden   [NN];
  logic [31:0] pr1, pr2, acc, bb1, bb2;

  // Memory read pipeline and accumulator driven by the DUT's strobes.
  always @(posedge clk) begin
    pr1 <= 32'(in_mem[addr_max[3:0]]) * 32'(w_mem[addr_weight[5:0]]);
    pr2 <= pr1;
`ifdef FC_BIAS_EN
    bb1 <= 32'(bias_mem[bias_addr]);
    bb2 <= bb1;
    if (mac_load_bias) acc <= bb2;
    else if (mac_en) acc <= acc + pr2;
`else
    bb1 <= 32'd0;
    bb2 <= bb1;
    if (mac_en) acc <= mac_clr ? pr2 : acc + pr2;
`endif
  end

  int obs_first_done, obs_last_done, obs_n_done, obs_first_rd;

  // Compare process: every output against the schedule model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("rd_en", rd_en, e_rd[cyc]);
      chk("mac_en", mac_en, e_me[cyc]);
      chk("mac_clr", mac_clr, e_clr[cyc]);
      chk("result_we", result_we, e_we[cyc]);
      if (e_achk[cyc]) begin
        chk("addr_max", addr_max, e_am[cyc]);
        chk("addr_weight", addr_weight, e_aw[cyc]);
      end
      if (e_rchk[cyc]) chk("result_addr", result_addr, e_ra[cyc]);
      if (e_we[cyc]) chk("result_value", acc, golden[e_ra[cyc]]);
`ifdef FC_BIAS_EN
      chk("bias_rd_en", bias_rd_en, e_brd[cyc]);
      chk("mac_load_bias", mac_load_bias, e_lb[cyc]);
      if (e_brd[cyc]) chk("bias_addr", bias_addr, e_ba[cyc]);
`endif
      if (done) begin
        if (obs_first_done < 0) obs_first_done = cyc;
        obs_last_done = cyc;
        obs_n_done++;
      end
      if (rd_en && obs_first_rd < 0) obs_first_rd = cyc;
    end
  end

  // Drive the tables for cycles 0..len-1; cycle c spans edge c-1 to edge c.
  task automatic run_scenario(input int len);
    obs_first_done = -1; obs_last_done = -1; obs_n_done = 0; obs_first_rd = -1;
    for (int c = 0; c < len; c++) begin
      cyc   = c;
      rst   = rst_tbl[c];
      start = start_tbl[c];
      pause = pause_tbl[c];
      cmp_en = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    cmp_en = 1'b0;
    rst = 0; start = 0; pause = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      in_mem[i]   = 8'($urandom_range(0, 255));
      bias_mem[i] = 16'($urandom_range(0, 65535));
    end
    for (int i = 0; i < 64; i++) w_mem[i] = 16'($urandom_range(0, 65535));
    for (int n = 0; n < NN; n++) begin
      golden[n] = BIAS ? 32'(bias_mem[n]) : 32'd0;
      for (int i = 0; i < NI; i++) golden[n] += 32'(in_mem[i]) * 32'(w_mem[n*NI+i]);
    end

    // reset block
    rst = 1; start = 0; pause = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_mac", {mac_clr, mac_en, result_we}, 0);
    chk("rst_addrs", addr_max | addr_weight | result_addr, 0);
    rst = 0;
    @(posedge clk);
    #1;

    // nominal run
    init_tables();
    start_tbl[0] = 1;
    model_build(0);
    run_scenario(30);
    chk("nominal_done_cycle", obs_first_done, DONE_NOM);
    chk("nominal_first_rd", obs_first_rd, BIAS ? 2 : 1);
    chk("nominal_done_count", obs_n_done, 1);

    // pause in cycles 3-4
    init_tables();
    start_tbl[0] = 1;
    pause_tbl[3] = 1; pause_tbl[4] = 1;
    model_build(0);
    run_scenario(32);
    chk("pause_done_cycle", obs_first_done, BIAS ? 27 : 24);

    // stray starts while busy and during DONE
    init_tables();
    start_tbl[0] = 1;
    start_tbl[5] = 1;
    start_tbl[DONE_NOM] = 1;
    model_build(0);
    run_scenario(36);
    chk("stray_done_cycle", obs_first_done, DONE_NOM);
    chk("stray_done_count", obs_n_done, 1);

    // reset in cycle 9, restart at 13
    init_tables();
    start_tbl[0] = 1;
    rst_tbl[9] = 1;
    start_tbl[13] = 1;
    model_build(0);
    model_reset(9);
    model_build(13);
    run_scenario(13 + DONE_NOM + 4);
    chk("reset_restart_done", obs_last_done, BIAS ? 38 : 35);
    chk("reset_done_count", obs_n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Controller that sequences the fully-connected stage after max-pooling. It walks the max-pool result memory and the weight memory for every output neuron and drives the external MAC's clear/enable strobes, aligned to memory read latency. It writes one accumulated result per neuron and signals completion to the layer-level controller. It replaces free-running position counters with a single start/done-driven scheduler.

## Interface
- `dataWidthCount`, 10: width of the max-memory address (input index).
- `dataWidthWeightAddr`, 13: width of the weight-memory address; must hold `numInputs*numNeurons-1`.
- `dataWidthNeuron`, 4: width of the neuron index / result address.
- `numInputs`, 507: inputs per neuron (max-pool results).
- `numNeurons`, 10: output neurons.
- `memLatency`, 2: read latency (cycles) from `rd_en` to data valid at the MAC, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `pause` in 1: freezes address issue while high.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse at completion.
- `rd_en` out 1: read strobe to max and weight memories.
- `addr_max` out `dataWidthCount`: input index.
- `addr_weight` out `dataWidthWeightAddr`: running weight address.
- `mac_clr` out 1: MAC loads product instead of accumulating (first term of a neuron).
- `mac_en` out 1: MAC consumes the current product.
- `result_we` out 1: write strobe for the result memory.
- `result_addr` out `dataWidthNeuron`: current neuron index.

## Operation
- FSM states: IDLE, RUN, DRAIN, STORE, DONE.
- IDLE: all strobes low. `start` moves to RUN, clears `addr_max`, `addr_weight` and the neuron index.
- RUN: each cycle with `pause`=0, assert `rd_en` and increment both addresses after issue. When `addr_max`=`numInputs-1` is issued, go to DRAIN and reset `addr_max` to 0. `addr_weight` keeps counting across neurons. No multiplier is used.
- RUN with `pause`=1: `rd_en` is low and the addresses hold. The delay pipeline keeps shifting.
- DRAIN: exactly `memLatency` cycles, no reads. Then go to STORE.
- STORE: one cycle with `result_we`=1 and `result_addr`=neuron. If neuron=`numNeurons-1`, go to DONE. Otherwise increment neuron and return to RUN.
- DONE: one cycle with `done`=1, then IDLE.
- `mac_en` is `rd_en` delayed by `memLatency` through a shift register. `mac_clr` is the delayed "first read of neuron" flag, so it coincides with that neuron's first `mac_en`.
- `start` outside IDLE is ignored, including during DONE.
- `rst` wins over everything. On the next cycle the block is in IDLE, every output is 0, and the delay pipeline is cleared.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `mac_clr`, `mac_en` and `result_we` are 0. `addr_max`, `addr_weight` and `result_addr` are 0.
- `start` is sampled at edge 0. The first `rd_en` is in cycle 1.
- Per neuron without pause: `numInputs` RUN cycles, `memLatency` DRAIN cycles and 1 STORE cycle.
- `done` is in cycle `numNeurons*(numInputs+memLatency+1)+1`.
- Each pause cycle in RUN adds exactly one cycle.
- STORE is the cycle after the neuron's last `mac_en`. The MAC output is registered at that edge and is valid during STORE.
- `pause` in DRAIN, STORE or DONE has no effect.

## Configuration
- `FC_BIAS_EN` defined: adds a BIAS state, one cycle before each neuron's RUN. In BIAS, `bias_rd_en`=1 and `bias_addr`=neuron (extra ports, width 1 and `dataWidthNeuron`). `mac_load_bias` is asserted `memLatency` cycles later. The first weight product then uses `mac_en` with `mac_clr`=0. Each neuron gains 1 cycle.
- `FC_BIAS_EN` undefined: no bias ports and no BIAS state. `mac_clr` marks the first product of each neuron.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, STORE=3, DONE=4, BIAS=5);
  - the default `numInputs`, `numNeurons` and `memLatency` constants used by the neighbouring pooling and FC blocks.
- One sub-module, `latency_shift`: a parameterized `memLatency`-deep, 2-bit shift register carrying {first, valid} with synchronous clear. It is reused for the bias alignment.

## Test plan
All scenarios use `numInputs`=4, `numNeurons`=3, `memLatency`=2.
- Nominal run: `start` at edge 0 produces:
  - `rd_en` in cycles 1–4, `addr_max` 0..3, `addr_weight` 0..3;
  - `mac_en` in cycles 3–6, with `mac_clr` only in cycle 3;
  - `result_we` in cycle 7 with `result_addr`=0;
  - neuron 1 reads `addr_weight` 4..7 in cycles 8–11;
  - `done` in cycle 22, then `busy`=0.
- Pause: `pause`=1 in cycles 3–4 holds `addr_max`=2 with `rd_en` low in those cycles; `done` moves to cycle 24.
- `start` pulsed in cycles 5 and 22 is ignored; no second sequence follows.
- Reset in cycle 9: every output is 0 in cycle 10. A new `start` then restarts from `addr_weight`=0 and `done` follows 22 cycles later.
- Reference-model check: accumulate random 8-bit inputs × 16-bit weights through a MAC model. Each `result_we` value must equal the golden dot product for neurons 0–2.
- With `FC_BIAS_EN`:
  - `bias_rd_en` is high in cycle 1 (`bias_addr`=0) and `mac_load_bias` in cycle 3;
  - weight reads occur in cycles 2–5;
  - `done` arrives in cycle 25.
